// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared definitions for the instruction fetch unit: FSM state
//               encoding, the canonical NOP word and the default reset PC.
//               Also provides small helpers that slice decode fields out of a
//               32-bit instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // FSM state encoding. Kept as plain localparam constants over an explicit
  // 2-bit type so legacy tools that dislike enums still read it cleanly.
  localparam int unsigned c_STATE_W = 2;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam logic [1:0] c_ST_BOOT  = 2'd0;  // waiting one clock after reset
  localparam logic [1:0] c_ST_FETCH = 2'd1;  // memory request outstanding
  localparam logic [1:0] c_ST_HOLD  = 2'd2;  // instruction held for execute

  // addi x0, x0, 0 -- the canonical RISC-V NOP, loaded into instr on reset.
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

  // Default first fetch address after reset.
  localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

  // Decode-field helpers.
  function automatic logic [6:0] get_opcode(input logic [31:0] word);
    return word[6:0];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] word);
    return word[14:12];
  endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory read bus between the fetch unit (master)
//               and the instruction memory (slave).
//   imem_req   master->slave  read request, held high while waiting
//   imem_addr  master->slave  word-aligned fetch address
//   imem_rdata slave->master  instruction word
//   imem_valid slave->master  imem_rdata valid this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int Width = 32
);

  logic             imem_req;
  logic [Width-1:0] imem_addr;
  logic [31:0]      imem_rdata;
  logic             imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Single-issue instruction fetch stage. Requests one word from
//               instruction memory, holds it for the execute stage until it
//               retires, then advances the PC to either PC+4 or the ALU
//               branch/jump target.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   imem         instruction-memory bus (master side)
//   PCSel        1 = next PC from alu_target, 0 = PC+4 (sampled at retire)
//   alu_target   branch/jump target from the ALU (sampled at retire)
//   stall        execute stage is not ready to retire the held instruction
//   instr        held instruction word
//   opcode       instr[6:0]
//   funct3       instr[14:12]
//   pc           address of the held instruction
//   pc_plus4     pc + 4 (wraps)
//   instr_valid  instr/pc hold a fetched, not-yet-retired instruction
//   misaligned   one-cycle pulse after retiring to a target with [1:0] != 0
//   instret      retired-instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = Width'(c_RESET_PC_DEFAULT)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,

  fetch_unit_if.master          imem,

  input  wire logic             PCSel,
  input  wire logic [Width-1:0] alu_target,
  input  wire logic             stall,

  output logic [31:0]           instr,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [Width-1:0]      pc,
  output logic [Width-1:0]      pc_plus4,
  output logic                  instr_valid,
  output logic                  misaligned,
  output logic [31:0]           instret
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [Width-1:0] r_pc;
  logic [31:0]      r_instr;
  logic [31:0]      r_instret;
  logic             r_misaligned;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             w_in_fetch;
  logic             w_in_hold;
  logic             w_fetch_done;
  logic             w_retire;
  logic             w_target_misaligned;
  logic [Width-1:0] w_pc_plus4;
  logic [Width-1:0] w_next_pc;

  assign w_in_fetch   = (r_state == c_ST_FETCH);
  assign w_in_hold    = (r_state == c_ST_HOLD);

  // imem_valid only matters while a request is outstanding.
  assign w_fetch_done = w_in_fetch && imem.imem_valid;

  // PCSel/alu_target are only looked at on this edge.
  assign w_retire     = w_in_hold && !stall;

  // Unsigned add truncates to Width bits, giving the required wrap at 2^Width.
  assign w_pc_plus4   = r_pc + Width'(4);

  // Branch targets are forced word-aligned; the dropped bits are reported
  // through the misaligned pulse rather than silently hidden.
  assign w_next_pc    = PCSel ? {alu_target[Width-1:2], 2'b00} : w_pc_plus4;

  assign w_target_misaligned = PCSel && (alu_target[1:0] != 2'b00);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_BOOT:  w_state_nxt = c_ST_FETCH;
      c_ST_FETCH: if (w_fetch_done) w_state_nxt = c_ST_HOLD;
      c_ST_HOLD:  if (w_retire)     w_state_nxt = c_ST_FETCH;
      default:    w_state_nxt = c_ST_BOOT;  // recover from unused encoding
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instret <= 32'd0;
    end else if (w_retire) begin
      r_pc      <= w_next_pc;
      r_instret <= r_instret + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= c_NOP_INSTR;
    end else if (w_fetch_done) begin
      r_instr <= imem.imem_rdata;
    end
  end

  // Retire is always followed by a FETCH cycle, so this register naturally
  // falls back to zero after exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_retire && w_target_misaligned;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem.imem_req  = w_in_fetch;
  assign imem.imem_addr = r_pc;

  assign instr       = r_instr;
  assign opcode      = get_opcode(r_instr);
  assign funct3      = get_funct3(r_instr);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_valid = w_in_hold;
  assign misaligned  = r_misaligned;
  assign instret     = r_instret;

endmodule : fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter Width, default 32: datapath and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PCSel  input  1  from the main controller; 1 = take alu_target, 0 = take PC+4.
REQ-006 alu_target  input  Width  branch/jump target computed by the ALU.
REQ-007 stall  input  1  execute stage not ready to retire the held instruction.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  Width  word-aligned fetch address.
REQ-010 imem_rdata  input  32  instruction word returned by memory.
REQ-011 imem_valid  input  1  imem_rdata valid this cycle.
REQ-012 instr  output  32  held instruction word.
REQ-013 opcode  output  7  instr[6:0]; drives the controller opcode input.
REQ-014 funct3  output  3  instr[14:12]; drives the controller funct3 input.
REQ-015 pc  output  Width  address of the held instruction.
REQ-016 pc_plus4  output  Width  pc+4, modulo 2^Width; feeds WBSel link path.
REQ-017 instr_valid  output  1  instr/pc hold a fetched, not-yet-retired instruction.
REQ-018 misaligned  output  1  one-cycle pulse: taken target had nonzero bits [1:0].
REQ-019 instret  output  32  retired-instruction count.

Function
REQ-020 FSM states: BOOT, FETCH, HOLD.
REQ-021 BOOT -> FETCH on the first clock after rst_n deasserts; imem_req=0 in BOOT.
REQ-022 FETCH: imem_req=1, imem_addr=pc; on an edge with imem_valid=1, instr<=imem_rdata and next state is HOLD; otherwise stay in FETCH.
REQ-023 imem_valid is ignored in BOOT and HOLD.
REQ-024 HOLD: instr_valid=1, imem_req=0.
REQ-025 HOLD with stall=1: hold pc, instr, and instret unchanged.
REQ-026 HOLD with stall=0 (retire): pc<=next_pc; instret<=instret+1; next state is FETCH.
REQ-027 next_pc = PCSel ? {alu_target[Width-1:2],2'b00} : pc_plus4.
REQ-028 On retire with PCSel=1 and alu_target[1:0]!=0, misaligned=1 for exactly the following cycle; otherwise misaligned=0.
REQ-029 PCSel and alu_target are sampled only on the retire edge; they are don't-care at all other times.
REQ-030 pc wraps: pc=0xFFFF_FFFC with PCSel=0 retires to 0x0000_0000; instret wraps 0xFFFF_FFFF -> 0.
REQ-031 Minimum throughput is one instruction per 2 cycles: FETCH 1 cycle with imem_valid, then HOLD 1 cycle with stall=0.
REQ-032 instr_valid=0 in BOOT and FETCH.
REQ-033 opcode and funct3 are combinational slices of the held instr.

Reset
REQ-034 rst_n=0 asynchronously forces: state=BOOT, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0, imem_req=0, instr_valid=0, misaligned=0.
REQ-035 A reset during FETCH or HOLD abandons the pending fetch or held instruction; no retire is counted.

Structure
REQ-036 The shared package holds: the FSM state enum, the NOP constant 32'h0000_0013, and the RESET_PC default.
REQ-037 The block is a single module; the next-PC mux and adder are inline, with no sub-module.

Verification
REQ-038 Reset, then imem_valid=1 immediately with rdata=0x00500093 -> imem_addr=0x0 in cycle 1; instr_valid=1 and opcode=0x13 in cycle 2; after retire with PCSel=0, pc=0x4.
REQ-039 HOLD with stall=1 for 5 cycles -> pc, instr, and instret constant and imem_req=0; stall=0 -> exactly one instret increment.
REQ-040 Retire with PCSel=1, alu_target=0x0000_0102 -> pc=0x0000_0100, misaligned high for exactly 1 cycle.
REQ-041 pc=0xFFFF_FFFC, PCSel=0, retire -> pc=0x0, pc_plus4 in that state=0x4.
REQ-042 imem_valid held low for 3 cycles in FETCH -> imem_req stays 1, imem_addr stable, instr unchanged; a pulse of imem_valid during HOLD is ignored.
REQ-043 rst_n asserted mid-HOLD, asynchronously between edges -> outputs reach reset values before the next edge; instret=0; the next fetch uses RESET_PC.
